pmod_button_conditioner: RTL and testbench

- Upstream input stage for the PMOD pushbuttons.
- Synchronises, debounces and edge-detects two active-low PMOD button pins.
- Outputs clean active-high levels and single-cycle press/release pulses. These drive counter resets/enables (for example, the 1 Hz LED counter) instead of the raw pins.
- Targets the 12 MHz board clock.

---
 rtl/pmod_button_conditioner.sv | 169 ++++++++++++++++
 tb/tb_pmod_button_conditioner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pmod_button_conditioner.sv
// pmod_button_conditioner
// Synchronises, debounces and edge-detects two active-low PMOD button pins.
// Produces clean active-high levels and single-cycle press/release pulses.
//
// Ports:
//   clk          12 MHz system clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   pmod[1:0]    raw button pins, active-low, asynchronous to clk
//   btn_level    debounced state per channel, 1 = pressed
//   btn_press    one-cycle pulse per channel on accepted press
//   btn_release  one-cycle pulse per channel on accepted release
//   btn_long     one-cycle pulse per channel on long press
//
// Optional feature: define PMOD_BUTTON_LONGPRESS_EN to build the long-press
// detector; otherwise btn_long is tied to 2'b00.
module pmod_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned LONG_CYCLES     = 24000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pmod,
    output logic [1:0] btn_level,
    output logic [1:0] btn_press,
    output logic [1:0] btn_release,
    output logic [1:0] btn_long
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (LONG_CYCLES == 0) begin : g_bad_long
        $error("LONG_CYCLES must be nonzero");
    end

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [1:0]       sync;
        logic             p;
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic             level_q, level_nxt;
        logic             press_q, press_nxt;
        logic             release_q, release_nxt;

        // Two-flop synchroniser; resets to the released (high) pin level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync <= 2'b11;
            end else begin
                sync <= {sync[0], pmod[i]};
            end
        end

        assign p = ~sync[1];

        // FSM and output registers
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        // Next-state: a change is accepted after DEBOUNCE_CYCLES+1 stable samples
        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            level_nxt   = level_q;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            case (state)
                RELEASED: begin
                    if (p) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state_nxt = RELEASED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!p) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state_nxt = PRESSED;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
                        state_nxt   = RELEASED;
                        cnt_nxt     = '0;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt     = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;

`ifdef PMOD_BUTTON_LONGPRESS_EN
        logic [CNT_W-1:0] long_cnt;
        logic             long_q;

        // Long-press timer: restarts only on a fresh press, survives release bounces
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                long_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (state == PRESS_WAIT && state_nxt == PRESSED) begin
                    long_cnt <= '0;
                end else if ((state == PRESSED || state == RELEASE_WAIT) &&
                             long_cnt != CNT_W'(LONG_CYCLES)) begin
                    long_cnt <= long_cnt + CNT_W'(1);
                    long_q   <= (long_cnt + CNT_W'(1)) == CNT_W'(LONG_CYCLES);
                end
            end
        end

        assign btn_long[i] = long_q;
`else
        assign btn_long[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_pmod_button_conditioner.sv
// Scoreboard bench: stimulus queues expected pulse events, a monitor checks
// every cycle in which the DUT presents a pulse.
module tb_pmod_button_conditioner;

    localparam int unsigned DEB = 8;
    localparam int unsigned LNG = 40;
    localparam int unsigned LAT = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pmod;
    logic [1:0] btn_level, btn_press, btn_release, btn_long;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic [1:0]  lng;
        logic [1:0]  lvl;
    } ev_t;

    ev_t exp_q[$];

    pmod_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pmod       (pmod),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Queue an event expected on rising edge cyc+dly
    task automatic push_ev(input int unsigned dly, input logic [1:0] pr,
                           input logic [1:0] rl, input logic [1:0] lg,
                           input logic [1:0] lv);
        ev_t e;
        e.cyc = cyc + dly; e.press = pr; e.rel = rl; e.lng = lg; e.lvl = lv;
        exp_q.push_back(e);
    endtask

    task automatic check2(input string name, input logic [1:0] act,
                          input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if ((btn_press | btn_release | btn_long) != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cycle %0d press=%b release=%b long=%b level=%b, none expected",
                         cyc, btn_press, btn_release, btn_long, btn_level);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.press !== btn_press || e.rel !== btn_release ||
                    e.lng !== btn_long || e.lvl !== btn_level) begin
                    errors++;
                    $display("FAIL pulse_event: got cycle %0d p=%b r=%b l=%b lv=%b, expected cycle %0d p=%b r=%b l=%b lv=%b",
                             cyc, btn_press, btn_release, btn_long, btn_level,
                             e.cyc, e.press, e.rel, e.lng, e.lvl);
                end
            end
        end
    end

    initial begin
        // 1. Reset with both buttons held
        rst_n = 1'b0;
        pmod  = 2'b00;
        wait_cycles(3);
        check2("reset_level",   btn_level,   2'b00);
        check2("reset_press",   btn_press,   2'b00);
        check2("reset_release", btn_release, 2'b00);
        check2("reset_long",    btn_long,    2'b00);
        rst_n = 1'b1;
        push_ev(LAT, 2'b11, 2'b00, 2'b00, 2'b11);
        wait_cycles(15);
        check2("held_through_reset_level", btn_level, 2'b11);

        pmod = 2'b11;
        push_ev(LAT, 2'b00, 2'b11, 2'b00, 2'b00);
        wait_cycles(15);
        check2("both_released_level", btn_level, 2'b00);

        // 2. Clean press on channel 0
        pmod = 2'b10;
        push_ev(LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_cycles(20);
        check2("ch0_pressed_level", btn_level, 2'b01);

        // 4a. Short release glitch is rejected
        pmod = 2'b11;
        wait_cycles(3);
        pmod = 2'b10;
        wait_cycles(15);
        check2("release_glitch_level", btn_level, 2'b01);

        // 4b. Clean release
        pmod = 2'b11;
        push_ev(LAT, 2'b00, 2'b01, 2'b00, 2'b00);
        wait_cycles(15);
        check2("ch0_released_level", btn_level, 2'b00);

        // 3. Bounce rejection
        pmod = 2'b10; wait_cycles(5);
        pmod = 2'b11; wait_cycles(2);
        pmod = 2'b10; wait_cycles(5);
        pmod = 2'b11; wait_cycles(15);
        check2("bounce_level", btn_level, 2'b00);

        // 5a. Reset during PRESS_WAIT
        pmod = 2'b10;
        wait_cycles(7);
        rst_n = 1'b0;
        #1;
        check2("rst_press_wait_level", btn_level, 2'b00);
        pmod = 2'b11;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(15);
        check2("after_rst_pw_level", btn_level, 2'b00);

        // 5b. Reset while PRESSED clears outputs asynchronously
        pmod = 2'b10;
        push_ev(LAT, 2'b01, 2'b00, 2'b00, 2'b01);
        wait_cycles(15);
        check2("pre_rst_pressed_level", btn_level, 2'b01);
        rst_n = 1'b0;
        #1;
        check2("async_rst_level", btn_level, 2'b00);
        check2("async_rst_press", btn_press, 2'b00);
        pmod = 2'b11;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(15);
        check2("after_rst_pressed_level", btn_level, 2'b00);

        // 6. Long hold on channel 1
        pmod = 2'b01;
        push_ev(LAT, 2'b10, 2'b00, 2'b00, 2'b10);
`ifdef PMOD_BUTTON_LONGPRESS_EN
        push_ev(LAT + LNG, 2'b00, 2'b00, 2'b10, 2'b10);
`endif
        wait_cycles(100);
        check2("long_hold_level", btn_level, 2'b10);
        pmod = 2'b11;
        push_ev(LAT, 2'b00, 2'b10, 2'b00, 2'b00);
        wait_cycles(20);
        check2("final_level", btn_level, 2'b00);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected pulses never seen, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
